// File: rtl/seq_pkg.sv
// Shared encodings and defaults for the 11011 pattern generator.
// The state codes match the detector's present_state debug convention.
package seq_pkg;

  localparam int STATE_W = 3;
  localparam int SEQ_PATTERN_LEN = 5;
  localparam logic [SEQ_PATTERN_LEN-1:0] SEQ_PATTERN = 5'b11011;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_SHIFT = 3'd2,
    ST_GAP   = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/seq_shift_reg.sv
// Parallel-load, left-shift register exposing its MSB as the serial tap.
// Load takes priority over shift so a reload can coincide with the last shifted bit.
module seq_shift_reg #(
  parameter int WIDTH = 5
) (
  input  logic             i_clk,
  input  logic             i_clear,
  input  logic             i_load,
  input  logic             i_shift,
  input  logic [WIDTH-1:0] i_loadVal,
  output logic             o_msb
);

  logic [WIDTH-1:0] r_data;

  always_ff @(posedge i_clk) begin
    if (i_clear) begin
      r_data <= '0;
    end else if (i_load) begin
      r_data <= i_loadVal;
    end else if (i_shift) begin
      r_data <= r_data << 1;
    end
  end

  assign o_msb = r_data[WIDTH-1];

endmodule

// File: rtl/seq_gen_11011_moore.sv
// Moore generator that sends PATTERN MSB-first in bursts of N repetitions,
// with an optional run of idle zero bits between repetitions.
module seq_gen_11011_moore
  import seq_pkg::*;
#(
  parameter int                     PATTERN_LEN = SEQ_PATTERN_LEN,
  parameter logic [PATTERN_LEN-1:0] PATTERN     = SEQ_PATTERN,
  parameter int                     REPEAT_W    = 4,
  parameter int                     GAP_BITS    = 2
) (
  input  logic                clk_pulse,
  input  logic                clear,
  input  logic                start,
  input  logic [REPEAT_W-1:0] repeat_cnt,
  output logic                out,
  output logic                valid,
  output logic                busy,
  output logic                done,
  output logic [STATE_W-1:0]  present_state,
  output logic [2:0]          bit_idx
);

  localparam int GAP_W = (GAP_BITS > 0) ? $clog2(GAP_BITS + 1) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = (GAP_BITS > 0) ? GAP_W'(GAP_BITS - 1) : '0;
  localparam logic [2:0] LAST_IDX = 3'(PATTERN_LEN - 1);

  state_t              r_state;
  logic [REPEAT_W-1:0] r_remaining;
  logic [GAP_W-1:0]    r_gapCnt;
  logic [2:0]          r_bitIdx;
  logic                r_valid;
  logic                r_busy;
  logic                r_done;

  logic w_lastBit;
  logic w_more;
  logic w_gapDone;
  logic w_load;
  logic w_shift;
  logic w_msb;

  assign w_lastBit = (r_bitIdx == LAST_IDX);
  assign w_more    = (r_remaining > REPEAT_W'(1));
  assign w_gapDone = (r_state == ST_GAP) && (r_gapCnt == GAP_LAST);
  // Back-to-back mode reloads on the final bit edge so no dead cycle appears.
  assign w_load    = (r_state == ST_LOAD) || w_gapDone ||
                     ((r_state == ST_SHIFT) && w_lastBit && w_more && (GAP_BITS == 0));
  assign w_shift   = (r_state == ST_SHIFT);

  seq_shift_reg #(
    .WIDTH(PATTERN_LEN)
  ) u_shreg (
    .i_clk    (clk_pulse),
    .i_clear  (clear),
    .i_load   (w_load),
    .i_shift  (w_shift),
    .i_loadVal(PATTERN),
    .o_msb    (w_msb)
  );

  always_ff @(posedge clk_pulse) begin
    if (clear) begin
      r_state     <= ST_IDLE;
      r_remaining <= '0;
      r_gapCnt    <= '0;
      r_bitIdx    <= '0;
      r_valid     <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state <= ST_LOAD;
            r_busy  <= 1'b1;
          end
        end
        ST_LOAD: begin
          r_remaining <= (repeat_cnt == '0) ? REPEAT_W'(1) : repeat_cnt;
          r_bitIdx    <= '0;
          r_state     <= ST_SHIFT;
          r_valid     <= 1'b1;
        end
        ST_SHIFT: begin
          if (!w_lastBit) begin
            r_bitIdx <= r_bitIdx + 3'd1;
          end else if (w_more) begin
            r_remaining <= r_remaining - REPEAT_W'(1);
            if (GAP_BITS == 0) begin
              r_bitIdx <= '0;
            end else begin
              r_state  <= ST_GAP;
              r_valid  <= 1'b0;
              r_gapCnt <= '0;
            end
          end else begin
            r_state <= ST_DONE;
            r_valid <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        ST_GAP: begin
          if (w_gapDone) begin
            r_bitIdx <= '0;
            r_state  <= ST_SHIFT;
            r_valid  <= 1'b1;
          end else begin
            r_gapCnt <= r_gapCnt + GAP_W'(1);
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign out           = r_valid & w_msb;
  assign valid         = r_valid;
  assign busy          = r_busy;
  assign done          = r_done;
  assign present_state = r_state;
  assign bit_idx       = r_bitIdx;

endmodule

// File: tb/tb_seq_gen_11011_moore.sv
// Bench for the 11011 burst generator: one instance with a 2-bit idle gap and
// one back-to-back instance, both compared against a stream model built per burst.
module tb_seq_gen_11011_moore;

  logic       clk = 1'b0;
  logic       clear;
  logic       startG, startB;
  logic [3:0] cntG, cntB;
  logic       outG, validG, busyG, doneG;
  logic       outB, validB, busyB, doneB;
  logic [2:0] stateG, idxG, stateB, idxB;

  logic       sel;
  logic       sOut, sValid, sBusy, sDone;
  logic [2:0] sState, sIdx;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  seq_gen_11011_moore #(.GAP_BITS(2)) dutGap (
    .clk_pulse(clk), .clear(clear), .start(startG), .repeat_cnt(cntG),
    .out(outG), .valid(validG), .busy(busyG), .done(doneG),
    .present_state(stateG), .bit_idx(idxG)
  );

  seq_gen_11011_moore #(.GAP_BITS(0)) dutB2b (
    .clk_pulse(clk), .clear(clear), .start(startB), .repeat_cnt(cntB),
    .out(outB), .valid(validB), .busy(busyB), .done(doneB),
    .present_state(stateB), .bit_idx(idxB)
  );

  assign sOut   = sel ? outB   : outG;
  assign sValid = sel ? validB : validG;
  assign sBusy  = sel ? busyB  : busyG;
  assign sDone  = sel ? doneB  : doneG;
  assign sState = sel ? stateB : stateG;
  assign sIdx   = sel ? idxB   : idxG;

  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit which, input logic s, input logic [3:0] c);
    if (which) begin
      startB = s;
      cntB   = c;
    end else begin
      startG = s;
      cntG   = c;
    end
  endtask

  // Expected stream: n copies of the pattern MSB-first, gap zeros between copies.
  task automatic applyStimulus(input bit which, input int cnt, input bit abuse, input int clearAt);
    logic [4:0] pat;
    logic [4:0] win;
    bit         expV[$];
    bit         expO[$];
    int         expI[$];
    int         n, gap, det;
    pat = 5'b11011;
    n   = (cnt == 0) ? 1 : cnt;
    gap = which ? 0 : 2;
    for (int r = 0; r < n; r++) begin
      for (int b = 0; b < 5; b++) begin
        expV.push_back(1'b1);
        expO.push_back(pat[4-b]);
        expI.push_back(b);
      end
      if (r < n - 1) begin
        for (int g = 0; g < gap; g++) begin
          expV.push_back(1'b0);
          expO.push_back(1'b0);
          expI.push_back(0);
        end
      end
    end
    sel = which;
    win = '0;
    det = 0;
    @(negedge clk);
    drive(which, 1'b1, 4'(cnt));
    @(negedge clk);
    checkOutput("load_state", 8'(sState), 8'd1);
    checkOutput("load_busy", 8'(sBusy), 8'd1);
    checkOutput("load_valid", 8'(sValid), 8'd0);
    drive(which, 1'b0, 4'(cnt));
    for (int c = 0; c < expV.size(); c++) begin
      @(negedge clk);
      checkOutput("valid", 8'(sValid), 8'(expV[c]));
      checkOutput("out", 8'(sOut), 8'(expO[c]));
      checkOutput("busy", 8'(sBusy), 8'd1);
      checkOutput("state", 8'(sState), expV[c] ? 8'd2 : 8'd3);
      if (expV[c]) checkOutput("bit_idx", 8'(sIdx), 8'(expI[c]));
      win = {win[3:0], sOut};
      if (win == 5'b11011) det++;
      if (c == clearAt) begin
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        checkOutput("clr_state", 8'(sState), 8'd0);
        checkOutput("clr_out", 8'(sOut), 8'd0);
        checkOutput("clr_valid", 8'(sValid), 8'd0);
        checkOutput("clr_busy", 8'(sBusy), 8'd0);
        checkOutput("clr_done", 8'(sDone), 8'd0);
        drive(which, 1'b0, 4'd0);
        return;
      end
      if (abuse) drive(which, 1'($urandom_range(0, 1)), 4'($urandom));
    end
    @(negedge clk);
    checkOutput("done_pulse", 8'(sDone), 8'd1);
    checkOutput("done_state", 8'(sState), 8'd4);
    checkOutput("done_valid", 8'(sValid), 8'd0);
    if (abuse) drive(which, 1'b1, 4'($urandom));
    @(negedge clk);
    drive(which, 1'b0, 4'd0);
    checkOutput("idle_state", 8'(sState), 8'd0);
    checkOutput("idle_busy", 8'(sBusy), 8'd0);
    checkOutput("idle_done", 8'(sDone), 8'd0);
    @(negedge clk);
    checkOutput("stay_idle", 8'(sState), 8'd0);
    checkOutput("detections", 8'(det), 8'(n));
  endtask

  initial begin
    sel    = 1'b0;
    clear  = 1'b1;
    startG = 1'b1;
    startB = 1'b1;
    cntG   = 4'd3;
    cntB   = 4'd3;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("rst_state", 8'(stateG), 8'd0);
      checkOutput("rst_out", 8'(outG), 8'd0);
      checkOutput("rst_valid", 8'(validG), 8'd0);
      checkOutput("rst_busy", 8'(busyG), 8'd0);
      checkOutput("rst_done", 8'(doneG), 8'd0);
      checkOutput("rst_state_b2b", 8'(stateB), 8'd0);
    end
    clear  = 1'b0;
    startG = 1'b0;
    startB = 1'b0;
    @(negedge clk);

    applyStimulus(1'b0, 1, 1'b0, -1);
    applyStimulus(1'b0, 3, 1'b0, -1);
    applyStimulus(1'b1, 2, 1'b0, -1);
    applyStimulus(1'b0, 0, 1'b0, -1);
    applyStimulus(1'b1, 0, 1'b0, -1);
    applyStimulus(1'b0, 3, 1'b1, -1);
    applyStimulus(1'b1, 3, 1'b1, -1);
    applyStimulus(1'b0, 3, 1'b0, 9);
    applyStimulus(1'b0, 3, 1'b0, -1);
    for (int k = 0; k < 8; k++) begin
      applyStimulus(1'($urandom_range(0, 1)), int'($urandom_range(0, 6)),
                    1'($urandom_range(0, 1)), -1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
